// File: rtl/mips_cpu_mem_ctrl_pkg.sv
// mips_cpu_pkg
// Shared types and constants for the MIPS multicycle CPU data-memory path.
// Contents:
//   mem_op_t    load/store operation code presented by the CPU MEM state
//   state_t     bus controller states (IDLE, BUS, RESP)
//   BE_*        Avalon byteenable patterns for word and half-word accesses
//   is_store    helper that classifies an op as a store
package mips_cpu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd7,
    OP_SH  = 4'd8,
    OP_SW  = 4'd9
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  function automatic logic is_store(input mem_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_cpu_mem_ctrl_load_align.sv
// mips_cpu_load_align
// Purely combinational load-result formatter. Picks the addressed lanes out of
// the Avalon read word and sign/zero-extends them, or merges them with the old
// rt value for the unaligned LWL/LWR pair. Store and unknown ops return 0.
// Ports:
//   op        registered load/store operation
//   offset    effective byte offset within the word (already forced for half/word ops)
//   readdata  word returned by the Avalon slave
//   rt_old    rt register value at request time (LWL/LWR merge source)
//   rsp_rdata formatted load result
module mips_cpu_load_align
  import mips_cpu_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  offset,
  input  logic [31:0] readdata,
  input  logic [31:0] rt_old,
  output logic [31:0] rsp_rdata
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  // Byte offset in bits; the addressed lane lands at bit 0 after the shift.
  assign shamt   = {offset, 3'b000};
  assign shifted = readdata >> shamt;

  // LWL moves the low (k+1) memory bytes to the top of rt and keeps the rest
  // of rt; LWR moves the high (4-k) memory bytes to the bottom of rt.
  always_comb begin
    rsp_rdata = '0;
    case (op)
      OP_LB:   rsp_rdata = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  rsp_rdata = {24'd0, shifted[7:0]};
      OP_LH:   rsp_rdata = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  rsp_rdata = {16'd0, shifted[15:0]};
      OP_LW:   rsp_rdata = readdata;
      OP_LWL:  rsp_rdata = (readdata << (5'd24 - shamt)) | (rt_old & (32'h00FF_FFFF >> shamt));
      OP_LWR:  rsp_rdata = shifted | (rt_old & ~(32'hFFFF_FFFF >> shamt));
      default: rsp_rdata = '0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_ctrl.sv
// mips_cpu_mem_ctrl
// Load/store bus controller between the multicycle CPU MEM state and an Avalon
// memory-mapped master. One request at a time: IDLE accepts, BUS holds the
// transaction through waitrequest, RESP pulses rsp_valid for one cycle.
// Optional build macro: MEM_CTRL_ALIGN_CHECK_EN rejects misaligned half/word
// accesses without a bus cycle (rsp_err=1). Without it, low address bits are
// ignored for half/word ops.
// Parameter:
//   WAIT_LIMIT  consecutive waitrequest-high cycles before abort (0 = never)
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         CPU request handshake
//   req_op/req_addr/req_wdata   operation, byte address, store data
//   req_rt_old                  old rt value for LWL/LWR
//   rsp_valid/rsp_rdata/rsp_err one-cycle response, load data, error flag
//   address/read/write          Avalon command (word-aligned address)
//   waitrequest                 Avalon stall
//   writedata/byteenable        Avalon store data and lanes
//   readdata                    Avalon load data
module mips_cpu_mem_ctrl
  import mips_cpu_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam logic [31:0] LIMIT = 32'(WAIT_LIMIT);

  state_t      state;
  mem_op_t     op_in;
  mem_op_t     op_q;
  logic [1:0]  off_in;
  logic [1:0]  off_q;
  logic [31:0] rt_old_q;
  logic [31:0] wait_cnt;
  logic [31:0] wait_next;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] load_data;
  logic        reject;

  assign op_in     = mem_op_t'(req_op);
  assign req_ready = (state == ST_IDLE);
  assign wait_next = wait_cnt + 32'd1;

  // Effective lane offset, byte enables and lane-replicated store data for the
  // incoming request. Half/word ops drop the low address bits they ignore.
  always_comb begin
    off_in   = req_addr[1:0];
    be_in    = BE_WORD;
    wdata_in = req_wdata;
    case (op_in)
      OP_LH, OP_LHU: off_in = {req_addr[1], 1'b0};
      OP_LW, OP_SW:  off_in = 2'b00;
      OP_SB: begin
        be_in    = 4'b0001 << req_addr[1:0];
        wdata_in = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        off_in   = {req_addr[1], 1'b0};
        be_in    = req_addr[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_in = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  // Misaligned half/word accesses are answered with an error and no bus cycle.
  always_comb begin
    reject = 1'b0;
    case (op_in)
      OP_LH, OP_LHU, OP_SH: reject = req_addr[0];
      OP_LW, OP_SW:         reject = |req_addr[1:0];
      default:              reject = 1'b0;
    endcase
  end
`else
  assign reject = 1'b0;
`endif

  mips_cpu_load_align u_load_align (
    .op        (op_q),
    .offset    (off_q),
    .readdata  (readdata),
    .rt_old    (rt_old_q),
    .rsp_rdata (load_data)
  );

  // Controller FSM; all bus and response outputs are registered here so they
  // stay stable for the whole BUS state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_LB;
      off_q      <= 2'b00;
      rt_old_q   <= '0;
      wait_cnt   <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= op_in;
            off_q     <= off_in;
            rt_old_q  <= req_rt_old;
            wait_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (reject) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= ST_RESP;
            end else begin
              address    <= {req_addr[31:2], 2'b00};
              writedata  <= wdata_in;
              byteenable <= be_in;
              read       <= ~is_store(op_in);
              write      <= is_store(op_in);
              state      <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (!waitrequest) begin
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_next;
            if ((LIMIT != 32'd0) && (wait_next == LIMIT)) begin
              read      <= 1'b0;
              write     <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= ST_RESP;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
